fwd_hazard_unit: RTL and testbench



---
 rtl/fwd_hazard_unit.sv | 91 +++++++++
 tb/tb_fwd_hazard_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand-forwarding select and load-use interlock between
// ID and EX. Keeps its own shift pipeline of in-flight writers (EX onward),
// resolves each ID source to the youngest matching writer, and holds ID while
// that writer is a load whose data is not yet forwardable.
//
// Handshake: stall is a same-cycle hold request to the front end. While
// stall=1 the ID instruction is held in place and a bubble enters EX. An ID
// instruction advances into EX on a clock edge where
// id_valid=1, stall=0 and flush=0. The EX side never back-pressures.
module fwd_hazard_unit #(
    parameter int NUM_SRC   = 2,
    parameter int RA_W      = 5,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 1,
    parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [NUM_SRC*RA_W-1:0]  id_rs,
    input  logic [NUM_SRC-1:0]       id_rs_used,
    input  logic [RA_W-1:0]          id_rd,
    input  logic                     id_reg_write,
    input  logic                     id_is_load,
    input  logic                     flush,
    output logic                     stall,
    output logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel,
    output logic [15:0]              stall_cycles
);

    // In-flight writer tracking; index 0 is EX, index j is j stages past EX.
    logic [FWD_DEPTH-1:0] trk_valid;
    logic [FWD_DEPTH-1:0] trk_wr;
    logic [FWD_DEPTH-1:0] trk_load;
    logic [RA_W-1:0]      trk_rd [FWD_DEPTH];

    logic [NUM_SRC*SEL_W-1:0] sel_next;
    logic [NUM_SRC-1:0]       src_haz;
    logic                     hazard;
    logic                     enter_ex;

    // Resolve each source to the youngest writer; scanning oldest to
    // youngest lets the youngest match overwrite any older one.
    always_comb begin
        sel_next = '0;
        src_haz  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int j = FWD_DEPTH - 1; j >= 0; j--) begin
                if (id_valid && id_rs_used[i] && trk_valid[j] && trk_wr[j] &&
                    (trk_rd[j] != '0) && (trk_rd[j] == id_rs[i*RA_W +: RA_W])) begin
                    sel_next[i*SEL_W +: SEL_W] = SEL_W'(j + 1);
                    src_haz[i]                 = trk_load[j] && ((j + 1) <= LOAD_LAT);
                end
            end
        end
    end

    // A flush kills the ID instruction, so it can never be held.
    always_comb begin
        hazard   = |src_haz;
        stall    = hazard && !flush;
        enter_ex = id_valid && !stall && !flush;
    end

    // Advance the writer pipeline, register EX forward selects, count stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trk_valid    <= '0;
            trk_wr       <= '0;
            trk_load     <= '0;
            for (int j = 0; j < FWD_DEPTH; j++) begin
                trk_rd[j] <= '0;
            end
            ex_fwd_sel   <= '0;
            stall_cycles <= '0;
        end else begin
            trk_valid <= {trk_valid[FWD_DEPTH-2:0], enter_ex};
            trk_wr    <= {trk_wr[FWD_DEPTH-2:0], enter_ex && id_reg_write};
            trk_load  <= {trk_load[FWD_DEPTH-2:0], enter_ex && id_is_load};
            trk_rd[0] <= id_rd;
            for (int j = 1; j < FWD_DEPTH; j++) begin
                trk_rd[j] <= trk_rd[j-1];
            end
            ex_fwd_sel <= enter_ex ? sel_next : '0;
            if (stall && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: three instances (default, LOAD_LAT=2,
// LOAD_LAT=16) share one stimulus stream; each step checks the instance
// whose configuration the step exercises.
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_is_load;
    logic        flush;

    logic        stall1, stall2, stall3;
    logic [3:0]  sel1, sel2;
    logic [9:0]  sel3;
    logic [15:0] cnt1, cnt2, cnt3;

    int n_checks = 0;
    int n_errors = 0;

    fwd_hazard_unit u_dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .flush(flush), .stall(stall1),
        .ex_fwd_sel(sel1), .stall_cycles(cnt1)
    );

    fwd_hazard_unit #(.FWD_DEPTH(3), .LOAD_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .flush(flush), .stall(stall2),
        .ex_fwd_sel(sel2), .stall_cycles(cnt2)
    );

    fwd_hazard_unit #(.FWD_DEPTH(17), .LOAD_LAT(16)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .flush(flush), .stall(stall3),
        .ex_fwd_sel(sel3), .stall_cycles(cnt3)
    );

    // Clock generation
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs0,
                         input logic [1:0] used, input logic [4:0] rd,
                         input logic wr, input logic ld);
        id_valid     = v;
        id_rs        = {rs1, rs0};
        id_rs_used   = used;
        id_rd        = rd;
        id_reg_write = wr;
        id_is_load   = ld;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_stall1", stall1, 0);
        check("rst_sel1", sel1, 0);
        check("rst_cnt1", cnt1, 0);
        check("rst_sel2", sel2, 0);
        check("rst_cnt3", cnt3, 0);

        // ALU back-to-back: add x5 ; sub x6,x5,x5
        drive(1, 0, 0, 2'b00, 5, 1, 0); tick();
        drive(1, 5, 5, 2'b11, 6, 1, 0); #1;
        check("alu_b2b_stall", stall1, 0);
        tick(); idle();
        check("alu_b2b_sel", sel1, 4'b0101);

        // One independent instruction between
        drive(1, 0, 0, 2'b00, 5, 1, 0); tick();
        drive(1, 0, 0, 2'b00, 10, 1, 0); tick();
        drive(1, 5, 5, 2'b11, 6, 1, 0); #1;
        check("alu_gap1_stall", stall1, 0);
        tick(); idle();
        check("alu_gap1_sel", sel1, 4'b1010);

        // Two independent instructions between: writer has left the window
        drive(1, 0, 0, 2'b00, 5, 1, 0); tick();
        drive(1, 0, 0, 2'b00, 10, 1, 0); tick();
        drive(1, 0, 0, 2'b00, 11, 1, 0); tick();
        drive(1, 5, 5, 2'b11, 6, 1, 0); tick(); idle();
        check("alu_gap2_sel", sel1, 4'b0000);

        // Load-use, defaults: lw x7 ; add x8,x7,x0 (rs2 unused)
        do_reset();
        drive(1, 0, 0, 2'b00, 7, 1, 1); tick();
        drive(1, 0, 7, 2'b01, 8, 1, 0); #1;
        check("lu1_stall_c0", stall1, 1);
        tick();
        check("lu1_bubble_sel", sel1, 0);
        check("lu1_cnt", cnt1, 1);
        check("lu1_stall_c1", stall1, 0);
        tick(); idle();
        check("lu1_sel", sel1, 4'b0010);

        // Load-use, LOAD_LAT=2: two stall cycles then sel=3
        do_reset();
        drive(1, 0, 0, 2'b00, 3, 1, 1); tick();
        drive(1, 0, 3, 2'b01, 11, 1, 0); #1;
        check("lu2_stall_c0", stall2, 1);
        tick();
        check("lu2_stall_c1", stall2, 1);
        tick();
        check("lu2_stall_c2", stall2, 0);
        check("lu2_cnt", cnt2, 2);
        tick(); idle();
        check("lu2_sel", sel2, 4'b0011);

        // LOAD_LAT=2 with one filler: single stall cycle
        drive(1, 0, 0, 2'b00, 3, 1, 1); tick();
        drive(1, 0, 0, 2'b00, 12, 1, 0); tick();
        drive(1, 0, 3, 2'b01, 11, 1, 0); #1;
        check("lu2f_stall_c0", stall2, 1);
        tick();
        check("lu2f_stall_c1", stall2, 0);
        tick(); idle();
        check("lu2f_sel", sel2, 4'b0011);

        // Double write: youngest writer wins
        do_reset();
        drive(1, 0, 0, 2'b00, 4, 1, 0); tick();
        drive(1, 0, 0, 2'b00, 4, 1, 0); tick();
        drive(1, 4, 4, 2'b11, 13, 1, 0); #1;
        check("dbl_stall", stall1, 0);
        tick(); idle();
        check("dbl_sel", sel1, 4'b0101);

        // Load to x0 never forwards or stalls
        drive(1, 0, 0, 2'b00, 0, 1, 1); tick();
        drive(1, 0, 0, 2'b11, 13, 1, 0); #1;
        check("x0_stall", stall1, 0);
        tick(); idle();
        check("x0_sel", sel1, 0);

        // Load with reg_write=0 never forwards or stalls
        drive(1, 0, 0, 2'b00, 12, 0, 1); tick();
        drive(1, 12, 12, 2'b11, 13, 1, 0); #1;
        check("nowr_stall", stall1, 0);
        tick(); idle();
        check("nowr_sel", sel1, 0);

        // Unused sources give sel 0 even on a matching address
        drive(1, 0, 0, 2'b00, 14, 1, 0); tick();
        drive(1, 14, 14, 2'b00, 13, 1, 0); tick(); idle();
        check("unused_sel", sel1, 0);

        // Flush in the hazard cycle: no stall, bubble, counter unchanged
        drive(1, 0, 0, 2'b00, 9, 1, 1); tick();
        drive(1, 0, 9, 2'b01, 15, 1, 0); flush = 1'b1; #1;
        check("flush_stall", stall1, 0);
        tick(); flush = 1'b0;
        check("flush_sel", sel1, 0);
        check("flush_cnt", cnt1, 0);
        // Load is now one stage past EX: forwardable without a stall
        check("post_flush_stall", stall1, 0);
        tick(); idle();
        check("post_flush_sel", sel1, 4'b0010);

        // Reset in the middle of a LOAD_LAT=2 stall
        do_reset();
        drive(1, 0, 0, 2'b00, 3, 1, 1); tick();
        drive(1, 0, 3, 2'b01, 11, 1, 0); tick();
        check("mid_cnt_pre", cnt2, 1);
        check("mid_stall_pre", stall2, 1);
        rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
        check("mid_stall", stall2, 0);
        check("mid_sel", sel2, 0);
        check("mid_cnt", cnt2, 0);

        // Saturation: self-dependent load held in ID on the LOAD_LAT=16 unit
        do_reset();
        drive(1, 0, 3, 2'b01, 3, 1, 1);
        repeat (18) tick();
        check("sat_cnt_early", cnt3, 16);
        check("sat_sel_early", sel3, 17);
        repeat (69982) tick();
        check("sat_cnt_hold", cnt3, 16'hFFFF);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
